// File: rtl/ymux_rr_stage.sv
// N-channel registered mux stage: fixed-select or round-robin pick of one valid/ready input into a single output register.
// Latency: 1 cycle from input transfer to out_valid; accept-and-reload in the same cycle keeps one word per cycle.
// Backpressure: every in_ready drops while the output register is full and out_ready is low; held data stays stable.
module ymux_rr_stage #(
    parameter int SIZE = 32,
    parameter int N    = 4,
    parameter int SELW = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mode,
    input  logic [SELW-1:0]   sel,
    input  logic [N-1:0]      in_valid,
    input  logic [N*SIZE-1:0] in_data,
    output logic [N-1:0]      in_ready,
    output logic              out_valid,
    output logic [SIZE-1:0]   out_data,
    output logic [SELW-1:0]   out_chan,
    input  logic              out_ready
);

    logic [SELW-1:0] rr_ptr;
    logic            load_en;
    logic [N-1:0]    grant;
    logic            win_any;
    logic [SELW-1:0] win_idx;
    logic [SIZE-1:0] win_data;
    logic [SELW:0]   scan_sum;
    logic [SELW-1:0] scan_idx;

    assign load_en = !out_valid || out_ready;

    // Grant is forced to zero during reset so no transfer is reported while the
    // output register is being cleared.
    always_comb begin
        grant    = '0;
        win_any  = 1'b0;
        win_idx  = '0;
        scan_sum = '0;
        scan_idx = '0;
        if (!reset && load_en) begin
            if (!mode) begin
                // A sel value with no matching channel simply produces no grant.
                for (int i = 0; i < N; i++) begin
                    if (sel == SELW'(i) && in_valid[i]) begin
                        grant[i] = 1'b1;
                        win_any  = 1'b1;
                        win_idx  = SELW'(i);
                    end
                end
            end else begin
                // Walk channels starting at rr_ptr; rr_ptr < N so one subtraction wraps.
                for (int k = 0; k < N; k++) begin
                    scan_sum = {1'b0, rr_ptr} + (SELW+1)'(k);
                    if (scan_sum >= (SELW+1)'(N)) begin
                        scan_sum = scan_sum - (SELW+1)'(N);
                    end
                    scan_idx = scan_sum[SELW-1:0];
                    if (!win_any && in_valid[scan_idx]) begin
                        grant[scan_idx] = 1'b1;
                        win_any         = 1'b1;
                        win_idx         = scan_idx;
                    end
                end
            end
        end
    end

    // Grant is at most one-hot, so an OR of the gated lanes is the mux.
    always_comb begin
        win_data = '0;
        for (int i = 0; i < N; i++) begin
            if (grant[i]) begin
                win_data = win_data | in_data[i*SIZE +: SIZE];
            end
        end
    end

    assign in_ready = grant;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_chan  <= '0;
            rr_ptr    <= '0;
        end else begin
            if (win_any) begin
                out_valid <= 1'b1;
                out_data  <= win_data;
                out_chan  <= win_idx;
                if (mode) begin
                    rr_ptr <= (win_idx == SELW'(N-1)) ? '0 : win_idx + SELW'(1);
                end
            end else if (out_ready) begin
                // Data and channel are left as-is after the word drains.
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ymux_rr_stage.sv
// Bench for ymux_rr_stage: directed vector table, hand sequences for reset/stall corners, then random vs a queue-free model.
module tb_ymux_rr_stage;

    localparam int SIZE = 32;
    localparam int N    = 4;
    localparam int SELW = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic              mode;
    logic [SELW-1:0]   sel;
    logic [N-1:0]      in_valid;
    logic [N*SIZE-1:0] in_data;
    logic [N-1:0]      in_ready;
    logic              out_valid;
    logic [SIZE-1:0]   out_data;
    logic [SELW-1:0]   out_chan;
    logic              out_ready;

    logic [SIZE-1:0]   ch_data [N];

    int checks   = 0;
    int failures = 0;

    // Reference state: what the output register should hold and where the scan starts.
    bit          m_valid;
    logic [31:0] m_data;
    int          m_chan;
    int          m_ptr;

    for (genvar g = 0; g < N; g++) begin : g_pack
        assign in_data[g*SIZE +: SIZE] = ch_data[g];
    end

    always #5 clk = ~clk;

    ymux_rr_stage #(.SIZE(SIZE), .N(N), .SELW(SELW)) dut (
        .clk       (clk),
        .reset     (reset),
        .mode      (mode),
        .sel       (sel),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_chan  (out_chan),
        .out_ready (out_ready)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_data  = '0;
        m_chan  = 0;
        m_ptr   = 0;
    endtask

    // Channel that wins this cycle under the stated rules, or -1 for none.
    function automatic int model_grant();
        if (reset) return -1;
        if (m_valid && !out_ready) return -1;
        if (mode == 1'b0) begin
            if (int'(sel) < N && in_valid[sel]) return int'(sel);
            return -1;
        end
        for (int k = 0; k < N; k++) begin
            int c;
            c = (m_ptr + k) % N;
            if (in_valid[c]) return c;
        end
        return -1;
    endfunction

    task automatic model_edge();
        int g;
        g = model_grant();
        if (g >= 0) begin
            m_valid = 1'b1;
            m_data  = ch_data[g];
            m_chan  = g;
            if (mode) m_ptr = (g + 1) % N;
        end else if (out_ready) begin
            m_valid = 1'b0;
        end
    endtask

    // One clock with hand-derived expectations: in_ready before the edge, output register after it.
    task automatic hcycle(input string name, input logic md, input logic [SELW-1:0] s,
                          input logic [N-1:0] v, input logic ordy, input logic [N-1:0] e_rdy,
                          input logic e_v, input logic [SELW-1:0] e_ch, input logic [SIZE-1:0] e_d);
        mode      = md;
        sel       = s;
        in_valid  = v;
        out_ready = ordy;
        #1;
        chk({name, ".in_ready"}, 64'(in_ready), 64'(e_rdy));
        @(posedge clk);
        model_edge();
        #1;
        chk({name, ".out_valid"}, 64'(out_valid), 64'(e_v));
        chk({name, ".out_chan"}, 64'(out_chan), 64'(e_ch));
        chk({name, ".out_data"}, 64'(out_data), 64'(e_d));
    endtask

    typedef struct {
        logic            md;
        logic [SELW-1:0] s;
        logic [N-1:0]    v;
        logic            ordy;
        logic [N-1:0]    rdy;
        logic            ov;
        logic [SELW-1:0] ch;
    } vec_t;

    vec_t tbl [20];

    initial begin
        // mode sel valid ordy | in_ready out_valid out_chan (data = A0+chan)
        tbl[0]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0};
        tbl[1]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1};
        tbl[2]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2};
        tbl[3]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3};
        tbl[4]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0};
        tbl[5]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1};
        tbl[6]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2};
        tbl[7]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3};
        tbl[8]  = '{1'b0, 2'd2, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2};
        tbl[9]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0};
        tbl[10] = '{1'b1, 2'd0, 4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2};
        tbl[11] = '{1'b1, 2'd0, 4'b0010, 1'b1, 4'b0010, 1'b1, 2'd1};
        tbl[12] = '{1'b1, 2'd0, 4'b1001, 1'b1, 4'b1000, 1'b1, 2'd3};
        tbl[13] = '{1'b1, 2'd0, 4'b1001, 1'b1, 4'b0001, 1'b1, 2'd0};
        tbl[14] = '{1'b0, 2'd3, 4'b0111, 1'b1, 4'b0000, 1'b0, 2'd0};
        tbl[15] = '{1'b1, 2'd0, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0};
        tbl[16] = '{1'b0, 2'd2, 4'b0100, 1'b0, 4'b0100, 1'b1, 2'd2};
        tbl[17] = '{1'b1, 2'd0, 4'b1111, 1'b0, 4'b0000, 1'b1, 2'd2};
        tbl[18] = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1};
        tbl[19] = '{1'b1, 2'd0, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd1};

        for (int i = 0; i < N; i++) ch_data[i] = 32'hA0 + 32'(i);
        reset     = 1'b1;
        mode      = 1'b1;
        sel       = '0;
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        model_reset();

        // Reset holds everything clear even with every channel requesting.
        repeat (2) @(posedge clk);
        #1;
        chk("rst.out_valid", 64'(out_valid), 64'd0);
        chk("rst.out_data", 64'(out_data), 64'd0);
        chk("rst.out_chan", 64'(out_chan), 64'd0);
        chk("rst.in_ready", 64'(in_ready), 64'd0);
        reset = 1'b0;

        for (int i = 0; i < 20; i++) begin
            hcycle($sformatf("tbl%0d", i), tbl[i].md, tbl[i].s, tbl[i].v, tbl[i].ordy,
                   tbl[i].rdy, tbl[i].ov, tbl[i].ch, ch_data[tbl[i].ch]);
        end

        // Fixed select delivers the selected word; rr pointer stays at 2.
        ch_data[2] = 32'hDEADBEEF;
        hcycle("fixsel", 1'b0, 2'd2, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 32'hDEADBEEF);

        // Stall: held word from ch1 stays put, nothing is accepted.
        ch_data[1] = 32'h12345678;
        hcycle("bp.load", 1'b0, 2'd1, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 32'h12345678);
        for (int i = 0; i < 3; i++) begin
            hcycle($sformatf("bp.stall%0d", i), 1'b1, 2'd0, 4'b1111, 1'b0,
                   4'b0000, 1'b1, 2'd1, 32'h12345678);
        end
        // Drain and reload in one cycle: scan resumes at ptr=2.
        hcycle("bp.release", 1'b1, 2'd0, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 32'hDEADBEEF);

        // Async reset discards the held word without waiting for a clock.
        reset = 1'b1;
        #1;
        chk("midrst.out_valid", 64'(out_valid), 64'd0);
        chk("midrst.out_data", 64'(out_data), 64'd0);
        chk("midrst.out_chan", 64'(out_chan), 64'd0);
        chk("midrst.in_ready", 64'(in_ready), 64'd0);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        hcycle("postrst.first", 1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, ch_data[0]);

        // Random traffic against the reference model.
        for (int cyc = 0; cyc < 1000; cyc++) begin
            int g;
            logic [N-1:0] exp_rdy;
            for (int i = 0; i < N; i++) ch_data[i] = $urandom;
            in_valid  = N'($urandom);
            mode      = 1'($urandom);
            sel       = SELW'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            g = model_grant();
            exp_rdy = (g >= 0) ? N'(1 << g) : '0;
            chk($sformatf("rnd%0d.in_ready", cyc), 64'(in_ready), 64'(exp_rdy));
            @(posedge clk);
            model_edge();
            #1;
            chk($sformatf("rnd%0d.out_valid", cyc), 64'(out_valid), 64'(m_valid));
            chk($sformatf("rnd%0d.out_chan", cyc), 64'(out_chan), 64'(m_chan));
            chk($sformatf("rnd%0d.out_data", cyc), 64'(out_data), 64'(m_data));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
